// File: rtl/apb_mem_ctrl.sv
`timescale 1ns/1ps
// apb_mem_ctrl: APB slave that turns each transfer into one registered access
// on a combinational-read word memory, with optional wait states and range check.
module apb_mem_ctrl #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_SIZE    = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         psel,
    input  logic                         penable,
    input  logic                         pwrite,
    input  logic [ADDR_WIDTH-1:0]        paddr,
    input  logic [DATA_WIDTH-1:0]        pwdata,
    input  logic [3:0]                   pstrb,
    output logic [DATA_WIDTH-1:0]        prdata,
    output logic                         pready,
    output logic                         pslverr,
    output logic [$clog2(MEM_SIZE)-1:0]  mem_address,
    output logic                         mem_wr,
    output logic                         mem_rd,
    output logic [3:0]                   mem_be,
    output logic [DATA_WIDTH-1:0]        mem_data_in,
    input  logic [DATA_WIDTH-1:0]        mem_data_out
);
    localparam int AW = $clog2(MEM_SIZE);
    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;
    state_t                state_q;
    logic [AW-1:0]         addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [3:0]            strb_q;
    logic                  write_q;
    logic                  err_q;
    logic [2:0]            cnt_q;
    logic [ADDR_WIDTH-1:0] idx_d;
    logic                  setup_d;
    logic                  oor_d;
    logic                  acc_d;
    logic                  write_d;
    logic [AW-1:0]         addr_d;
    logic [DATA_WIDTH-1:0] wdata_d;
    logic [3:0]            strb_d;
    // acc_d marks the edge entering ACCESS; with no wait states that is the setup edge itself
    always_comb begin
        idx_d   = paddr >> 2;
        setup_d = state_q == IDLE && psel && !penable;
        oor_d   = idx_d >= ADDR_WIDTH'(MEM_SIZE);
        acc_d   = (setup_d && !oor_d && WAIT_STATES == 0) ||
                  (state_q == WAIT && psel && cnt_q == 3'(WAIT_STATES - 1));
        addr_d  = state_q == IDLE ? idx_d[AW-1:0] : addr_q;
        wdata_d = state_q == IDLE ? pwdata : wdata_q;
        strb_d  = state_q == IDLE ? pstrb : strb_q;
        write_d = state_q == IDLE ? pwrite : write_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            strb_q      <= '0;
            write_q     <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            prdata      <= '0;
            pready      <= 1'b0;
            pslverr     <= 1'b0;
            mem_address <= '0;
            mem_wr      <= 1'b0;
            mem_rd      <= 1'b0;
            mem_be      <= '0;
            mem_data_in <= '0;
        end else begin
            mem_wr  <= acc_d && write_d && |strb_d;
            mem_rd  <= acc_d && !write_d;
            mem_be  <= !acc_d ? 4'h0 : write_d ? strb_d : 4'hF;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            if (acc_d) begin
                mem_address <= addr_d;
                if (write_d) mem_data_in <= wdata_d;
            end
            case (state_q)
                IDLE: if (setup_d) begin
                    addr_q  <= idx_d[AW-1:0];
                    wdata_q <= pwdata;
                    strb_q  <= pstrb;
                    write_q <= pwrite;
                    err_q   <= oor_d;
                    cnt_q   <= '0;
                    if (oor_d) begin
                        state_q <= RESP;
                        pready  <= 1'b1;
                        pslverr <= 1'b1;
                        prdata  <= '0;
                    end else begin
                        state_q <= WAIT_STATES > 0 ? WAIT : ACCESS;
                    end
                end
                WAIT: begin
                    if (!psel) state_q <= IDLE;
                    else if (acc_d) state_q <= ACCESS;
                    else cnt_q <= cnt_q + 3'd1;
                end
                ACCESS: begin
                    if (!psel) begin
                        state_q <= IDLE;
                    end else begin
                        state_q <= RESP;
                        pready  <= 1'b1;
                        prdata  <= write_q ? '0 : mem_data_out;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    err_q   <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_mem_ctrl.sv
`timescale 1ns/1ps
// tb_apb_mem_ctrl: two instances (0 and 3 wait states) driven by directed APB transfers,
// responses checked by a queue-based monitor, memory strobes captured for directed checks.
module tb_apb_mem_ctrl;
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          e0;
    } exp_t;
    logic        clk;
    logic        rst;
    logic        psel_v[2], penable_v[2], pwrite_v[2];
    logic [31:0] paddr_v[2], pwdata_v[2], prdata_v[2], mem_data_in_v[2], mem_data_out_v[2];
    logic [3:0]  pstrb_v[2], mem_be_v[2];
    logic        pready_v[2], pslverr_v[2], mem_wr_v[2], mem_rd_v[2];
    logic [7:0]  mem_address_v[2];
    logic [31:0] mem[2][256];
    exp_t        q0[$], q1[$];
    int          cyc, checks, failures;
    int          e0_v[2], wr_cnt[2], rd_cnt[2], wr_lat[2];
    logic [7:0]  w_addr[2];
    logic [3:0]  w_be[2], r_be[2];
    logic [31:0] w_data[2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        apb_mem_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_SIZE(256), .WAIT_STATES(g * 3)) u_dut (
            .clk(clk), .rst(rst), .psel(psel_v[g]), .penable(penable_v[g]), .pwrite(pwrite_v[g]),
            .paddr(paddr_v[g]), .pwdata(pwdata_v[g]), .pstrb(pstrb_v[g]), .prdata(prdata_v[g]),
            .pready(pready_v[g]), .pslverr(pslverr_v[g]), .mem_address(mem_address_v[g]),
            .mem_wr(mem_wr_v[g]), .mem_rd(mem_rd_v[g]), .mem_be(mem_be_v[g]),
            .mem_data_in(mem_data_in_v[g]), .mem_data_out(mem_data_out_v[g]));
        assign mem_data_out_v[g] = mem[g][mem_address_v[g]];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk)
        for (int d = 0; d < 2; d++)
            if (mem_wr_v[d])
                for (int b = 0; b < 4; b++)
                    if (mem_be_v[d][b]) mem[d][mem_address_v[d]][8*b +: 8] <= mem_data_in_v[d][8*b +: 8];

    task automatic chk(input string nm, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic mon(input int d);
        exp_t e;
        if (mem_wr_v[d]) begin
            wr_cnt[d]++;
            wr_lat[d] = cyc - e0_v[d] + 1;
            w_addr[d] = mem_address_v[d];
            w_be[d]   = mem_be_v[d];
            w_data[d] = mem_data_in_v[d];
        end
        if (mem_rd_v[d]) begin
            rd_cnt[d]++;
            r_be[d] = mem_be_v[d];
        end
        if (pready_v[d]) begin
            if ((d == 1 ? q1.size() : q0.size()) == 0) begin
                chk($sformatf("unexpected_pready_d%0d", d), pready_v[d], 0);
            end else begin
                if (d == 1) e = q1.pop_front();
                else e = q0.pop_front();
                chk($sformatf("prdata_d%0d", d), prdata_v[d], e.rdata);
                chk($sformatf("pslverr_d%0d", d), pslverr_v[d], e.err);
                chk($sformatf("latency_d%0d", d), cyc - e.e0 + 1, e.lat);
            end
        end else begin
            chk($sformatf("pslverr_without_pready_d%0d", d), pslverr_v[d], 0);
        end
    endtask

    always @(negedge clk) for (int d = 0; d < 2; d++) mon(d);

    task automatic apb(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] s, input logic [31:0] er, input logic ee);
        exp_t e;
        bit   done;
        done = 0;
        psel_v[d] = 1'b1; penable_v[d] = 1'b0; pwrite_v[d] = w;
        paddr_v[d] = a; pwdata_v[d] = wd; pstrb_v[d] = s;
        @(posedge clk); #1;
        e0_v[d] = cyc;
        e.rdata = er; e.err = ee; e.lat = ee ? 1 : 2 + 3 * d; e.e0 = cyc;
        if (d == 1) q1.push_back(e);
        else q0.push_back(e);
        penable_v[d] = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            done = pready_v[d];
        end
        chk($sformatf("pready_timeout_d%0d_a%0h", d, a), done, 1);
        @(posedge clk); #1;
        psel_v[d] = 1'b0; penable_v[d] = 1'b0;
    endtask

    task automatic rchk(input int d, input string nm);
        chk(nm, {prdata_v[d], pready_v[d], pslverr_v[d], mem_address_v[d], mem_wr_v[d],
                 mem_rd_v[d], mem_be_v[d], mem_data_in_v[d]}, 0);
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            psel_v[d] = 0; penable_v[d] = 0; pwrite_v[d] = 0;
            paddr_v[d] = 0; pwdata_v[d] = 0; pstrb_v[d] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        rchk(0, "reset_d0");
        rchk(1, "reset_d1");
        rst = 1'b0;
        @(posedge clk); #1;
        // zero wait states
        apb(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0);
        chk("wr_addr", w_addr[0], 4);
        chk("wr_be", w_be[0], 4'hF);
        chk("wr_data", w_data[0], 32'hDEADBEEF);
        chk("wr_lat", wr_lat[0], 1);
        apb(0, 0, 32'h10, 0, 4'h0, 32'hDEADBEEF, 0);
        chk("rd_cnt", rd_cnt[0], 1);
        chk("rd_be", r_be[0], 4'hF);
        apb(0, 1, 32'h10, 32'h11223344, 4'b0101, 0, 0);
        chk("partial_be", w_be[0], 4'b0101);
        apb(0, 0, 32'h10, 0, 4'h0, 32'hDE22BE44, 0);
        apb(0, 1, 32'h10, 32'hFFFFFFFF, 4'h0, 0, 0);
        chk("zero_strobe_wr_cnt", wr_cnt[0], 2);
        apb(0, 0, 32'h10, 0, 4'h0, 32'hDE22BE44, 0);
        apb(0, 1, 32'h3FC, 32'hCAFEF00D, 4'hF, 0, 0);
        chk("last_word_addr", w_addr[0], 255);
        apb(0, 0, 32'h3FC, 0, 4'h0, 32'hCAFEF00D, 0);
        apb(0, 0, 32'h400, 0, 4'h0, 0, 1);
        apb(0, 1, 32'h400, 32'h55555555, 4'hF, 0, 1);
        chk("oor_wr_cnt", wr_cnt[0], 3);
        chk("oor_rd_cnt", rd_cnt[0], 4);
        // access phase with no preceding setup
        psel_v[0] = 1; penable_v[0] = 1; pwrite_v[0] = 1; paddr_v[0] = 32'h10; pstrb_v[0] = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        psel_v[0] = 0; penable_v[0] = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("ignored_wr_cnt", wr_cnt[0], 3);
        // three wait states
        apb(1, 1, 32'h20, 32'h12345678, 4'hF, 0, 0);
        chk("ws_wr_addr", w_addr[1], 8);
        chk("ws_wr_lat", wr_lat[1], 4);
        apb(1, 0, 32'h20, 0, 4'h0, 32'h12345678, 0);
        chk("ws_rd_cnt", rd_cnt[1], 1);
        // abort in WAIT
        psel_v[1] = 1; penable_v[1] = 0; pwrite_v[1] = 1; paddr_v[1] = 32'h28;
        pwdata_v[1] = 32'h0BADF00D; pstrb_v[1] = 4'hF;
        @(posedge clk); #1;
        penable_v[1] = 1;
        @(posedge clk); #1;
        psel_v[1] = 0; penable_v[1] = 0;
        repeat (8) @(posedge clk);
        #1;
        chk("abort_wr_cnt", wr_cnt[1], 1);
        chk("abort_rd_cnt", rd_cnt[1], 1);
        // reset pulse while in WAIT
        psel_v[1] = 1; penable_v[1] = 0; pwrite_v[1] = 1; paddr_v[1] = 32'h24;
        pwdata_v[1] = 32'hAAAA5555; pstrb_v[1] = 4'hF;
        @(posedge clk); #1;
        penable_v[1] = 1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        rchk(1, "async_reset_d1");
        rchk(0, "async_reset_d0");
        @(posedge clk); #1;
        rst = 1'b0;
        psel_v[1] = 0; penable_v[1] = 0;
        repeat (8) @(posedge clk);
        #1;
        chk("reset_wr_cnt", wr_cnt[1], 1);
        apb(1, 0, 32'h20, 0, 4'h0, 32'h12345678, 0);
        chk("q0_empty", q0.size(), 0);
        chk("q1_empty", q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
